// File: rtl/frame_buffer_arbiter.sv
// Single-port frame-buffer arbiter: VGA reads take priority over a frame-clear sweep,
// which takes priority over FIFO-buffered edge-detector writes. One memory op per cycle.
module frame_buffer_arbiter #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_W     = 2
) (
  input  logic                          mainClk,
  input  logic                          reset,
  input  logic                          rdReq,
  input  logic [9:0]                    rdX,
  input  logic [8:0]                    rdY,
  output logic                          rdValid,
  output logic [DATA_W-1:0]             rdData,
  input  logic                          wrValid,
  input  logic [9:0]                    wrX,
  input  logic [8:0]                    wrY,
  input  logic [DATA_W-1:0]             wrData,
  output logic                          wrReady,
  input  logic                          clearReq,
  output logic                          clearBusy,
  output logic                          clearDone,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount,
  output logic [18:0]                   memAddr,
  output logic [DATA_W-1:0]             memWrData,
  output logic                          memWe,
  input  logic [DATA_W-1:0]             memRdData
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 19 + DATA_W;

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  state_t              state_q, state_d;
  logic [9:0]          cx_q, cx_d;
  logic [8:0]          cy_q, cy_d;
  logic                clear_busy_q, clear_busy_d;
  logic                clear_done_q, clear_done_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [18:0]         mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wr_data_q, mem_wr_data_d;
  logic                mem_we_q, mem_we_d;
  logic                rd_pend_q, rd_pend_d;
  logic                rd_valid_q, rd_valid_d;

  // Entry layout: {y[8:0], x[9:0], data}, so the upper 19 bits are the memory address.
  logic [ENTRY_W-1:0]  fifo_mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0]  head;

  logic                push;
  logic                pop;
  logic                grant_clear;
  logic                last_pix;
  logic                ready;

  assign ready       = (count_q < CNT_W'(FIFO_DEPTH));
  assign push        = wrValid & ready;
  assign grant_clear = !rdReq && (state_q == S_CLEAR);
  assign pop         = !rdReq && (state_q == S_IDLE) && (count_q != '0);
  assign last_pix    = (cx_q == 10'(H_ACTIVE - 1)) && (cy_q == 9'(V_ACTIVE - 1));
  assign head        = fifo_mem_q[rd_ptr_q];

  always_comb begin
    state_d       = state_q;
    cx_d          = cx_q;
    cy_d          = cy_q;
    clear_busy_d  = clear_busy_q;
    clear_done_d  = 1'b0;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    mem_we_d      = 1'b0;
    rd_pend_d     = rdReq;
    rd_valid_d    = rd_pend_q;

    if (rdReq) begin
      mem_addr_d = {rdY, rdX};
    end else if (grant_clear) begin
      mem_addr_d    = {cy_q, cx_q};
      mem_wr_data_d = '0;
      mem_we_d      = 1'b1;
    end else if (pop) begin
      mem_addr_d    = head[DATA_W +: 19];
      mem_wr_data_d = head[DATA_W-1:0];
      mem_we_d      = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (clearReq) begin
          state_d      = S_CLEAR;
          cx_d         = '0;
          cy_d         = '0;
          clear_busy_d = 1'b1;
        end
      end
      S_CLEAR: begin
        if (grant_clear) begin
          if (last_pix) begin
            state_d      = S_IDLE;
            clear_busy_d = 1'b0;
            clear_done_d = 1'b1;
            cx_d         = '0;
            cy_d         = '0;
          end else if (cx_q == 10'(H_ACTIVE - 1)) begin
            cx_d = '0;
            cy_d = cy_q + 9'd1;
          end else begin
            cx_d = cx_q + 10'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge mainClk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cx_q          <= '0;
      cy_q          <= '0;
      clear_busy_q  <= 1'b0;
      clear_done_q  <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      mem_we_q      <= 1'b0;
      rd_pend_q     <= 1'b0;
      rd_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cx_q          <= cx_d;
      cy_q          <= cy_d;
      clear_busy_q  <= clear_busy_d;
      clear_done_q  <= clear_done_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      mem_we_q      <= mem_we_d;
      rd_pend_q     <= rd_pend_d;
      rd_valid_q    <= rd_valid_d;
    end
  end

  always_ff @(posedge mainClk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {wrY, wrX, wrData};
  end

  assign wrReady   = ready;
  assign fifoCount = count_q;
  assign clearBusy = clear_busy_q;
  assign clearDone = clear_done_q;
  assign memAddr   = mem_addr_q;
  assign memWrData = mem_wr_data_q;
  assign memWe     = mem_we_q;
  assign rdValid   = rd_valid_q;
  assign rdData    = rd_valid_q ? memRdData : '0;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Scoreboard bench for frame_buffer_arbiter: a queue-based reference model predicts
// every cycle's memory command/status and every read return; a monitor compares.
module tb_frame_buffer_arbiter;
  localparam int H  = 4;
  localparam int V  = 2;
  localparam int D  = 8;
  localparam int DW = 2;

  logic          mainClk = 1'b0;
  logic          reset;
  logic          rdReq;
  logic [9:0]    rdX;
  logic [8:0]    rdY;
  logic          rdValid;
  logic [DW-1:0] rdData;
  logic          wrValid;
  logic [9:0]    wrX;
  logic [8:0]    wrY;
  logic [DW-1:0] wrData;
  logic          wrReady;
  logic          clearReq;
  logic          clearBusy;
  logic          clearDone;
  logic [3:0]    fifoCount;
  logic [18:0]   memAddr;
  logic [DW-1:0] memWrData;
  logic          memWe;
  logic [DW-1:0] memRdData = '0;

  always #5 mainClk = ~mainClk;

  frame_buffer_arbiter #(.H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(D), .DATA_W(DW)) dut (
    .mainClk(mainClk), .reset(reset),
    .rdReq(rdReq), .rdX(rdX), .rdY(rdY), .rdValid(rdValid), .rdData(rdData),
    .wrValid(wrValid), .wrX(wrX), .wrY(wrY), .wrData(wrData), .wrReady(wrReady),
    .clearReq(clearReq), .clearBusy(clearBusy), .clearDone(clearDone),
    .fifoCount(fifoCount), .memAddr(memAddr), .memWrData(memWrData), .memWe(memWe),
    .memRdData(memRdData)
  );

  function automatic logic [DW-1:0] memf(input logic [18:0] a);
    return a[1:0] ^ a[11:10];
  endfunction

  // SPRAM stand-in: read data appears the cycle after the command.
  always @(posedge mainClk) memRdData <= memf(memAddr);

  typedef struct {
    bit          rst;
    bit          we;
    logic [18:0] addr;
    logic [1:0]  wd;
    bit          busy;
    bit          done;
    int          cnt;
  } exp_t;
  typedef struct { int due; logic [1:0] d; } rd_t;
  typedef struct { logic [9:0] x; logic [8:0] y; logic [1:0] d; } wr_t;

  exp_t  exp_q[$];
  rd_t   rd_q[$];
  wr_t   m_fifo[$];
  int    cyc = 0;
  bit    m_clr = 0;
  int    m_idx = 0;
  logic [18:0] m_last = '0;
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", n, cyc, act, exp);
    end
  endtask

  // Reference model: arbitration by priority, FIFO as a queue, clear as a linear pixel index.
  exp_t e;
  int   pre;
  bit   was_clr;
  rd_t  r;
  wr_t  w;
  always @(posedge mainClk) begin
    cyc++;
    e.rst = 0; e.we = 0; e.addr = m_last; e.wd = '0; e.busy = 0; e.done = 0; e.cnt = 0;
    if (reset) begin
      m_fifo.delete(); rd_q.delete();
      m_clr = 0; m_idx = 0; m_last = '0; e.rst = 1; e.addr = '0;
    end else begin
      pre = m_fifo.size();
      was_clr = m_clr;
      if (rdReq) begin
        e.addr = {rdY, rdX};
        r.due = cyc + 1; r.d = memf(e.addr);
        rd_q.push_back(r);
      end else if (m_clr) begin
        e.we = 1; e.wd = '0;
        e.addr = {9'(m_idx / H), 10'(m_idx % H)};
        m_idx++;
        if (m_idx == H * V) begin m_clr = 0; e.done = 1; end
      end else if (pre > 0) begin
        w = m_fifo.pop_front();
        e.we = 1; e.addr = {w.y, w.x}; e.wd = w.d;
      end
      if (wrValid && pre < D) begin
        w.x = wrX; w.y = wrY; w.d = wrData;
        m_fifo.push_back(w);
      end
      if (!was_clr && clearReq) begin m_clr = 1; m_idx = 0; end
      m_last = e.addr;
      e.busy = m_clr;
      e.cnt  = m_fifo.size();
    end
    exp_q.push_back(e);
  end

  exp_t   m;
  rd_t    rr;
  always @(posedge mainClk) begin
    #1;
    if (exp_q.size() == 0) begin
      chk("exp_q_underflow", 1, 0);
    end else begin
      m = exp_q.pop_front();
      if (m.rst) begin
        chk("rst_memAddr", 32'(memAddr), 0);
        chk("rst_memWe", 32'(memWe), 0);
        chk("rst_memWrData", 32'(memWrData), 0);
        chk("rst_rdValid", 32'(rdValid), 0);
        chk("rst_clearBusy", 32'(clearBusy), 0);
        chk("rst_clearDone", 32'(clearDone), 0);
        chk("rst_fifoCount", 32'(fifoCount), 0);
        chk("rst_wrReady", 32'(wrReady), 1);
      end else begin
        chk("memWe", 32'(memWe), 32'(m.we));
        chk("memAddr", 32'(memAddr), 32'(m.addr));
        if (m.we) chk("memWrData", 32'(memWrData), 32'(m.wd));
        chk("clearBusy", 32'(clearBusy), 32'(m.busy));
        chk("clearDone", 32'(clearDone), 32'(m.done));
        chk("fifoCount", 32'(fifoCount), 32'(m.cnt));
        chk("wrReady", 32'(wrReady), 32'(m.cnt < D));
      end
    end
    if (rdValid) begin
      if (rd_q.size() == 0) chk("rdValid_unexpected", 1, 0);
      else begin
        rr = rd_q.pop_front();
        chk("rd_latency", 32'(cyc), 32'(rr.due));
        chk("rdData", 32'(rdData), 32'(rr.d));
      end
    end else begin
      chk("rdData_idle", 32'(rdData), 0);
      if (rd_q.size() != 0 && rd_q[0].due <= cyc) begin
        rr = rd_q.pop_front();
        chk("rdValid_missing", 0, 1);
      end
    end
  end

  task automatic tick(input bit rq, input int rx, input int ry,
                      input bit wv, input int wx, input int wy, input int wd, input bit cr);
    rdReq = rq; rdX = 10'(rx); rdY = 9'(ry);
    wrValid = wv; wrX = 10'(wx); wrY = 9'(wy); wrData = DW'(wd);
    clearReq = cr;
    @(negedge mainClk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    rdReq = 0; rdX = '0; rdY = '0; wrValid = 0; wrX = '0; wrY = '0; wrData = '0; clearReq = 0;
    repeat (3) @(negedge mainClk);
    reset = 1'b0;
    idle(5);
    // Three consecutive reads at (5,3).
    for (int i = 0; i < 3; i++) tick(1, 5, 3, 0, 0, 0, 0, 0);
    idle(4);
    // Fill the FIFO behind a held read, including pushes offered while full.
    for (int i = 0; i < 10; i++)
      tick(1, $urandom_range(0, 639), $urandom_range(0, 479),
           1, $urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 3), 0);
    idle(12);
    // Three queued writes held off by 10 read cycles.
    for (int i = 0; i < 3; i++) tick(1, i, i, 1, 100 + i, 7, i + 1, 0);
    for (int i = 0; i < 7; i++) tick(1, $urandom_range(0, 639), $urandom_range(0, 479), 0, 0, 0, 0, 0);
    idle(6);
    // Clear with writes queued during the sweep and a redundant clearReq mid-sweep.
    tick(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 1, 200 + i, 9, 3, i == 2);
    idle(12);
    // Clear stalled by reads.
    tick(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 12; i++) tick(i % 3 == 0, i, 1, 0, 0, 0, 0, 0);
    idle(4);
    // Reset with the sweep at cx=2, FIFO partly filled, then restart.
    tick(1, 1, 1, 1, 11, 2, 1, 1);
    tick(0, 0, 0, 1, 12, 2, 2, 0);
    tick(0, 0, 0, 1, 13, 2, 3, 0);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(2);
    tick(0, 0, 0, 0, 0, 0, 0, 1);
    idle(12);
    // Randomized mixed traffic.
    for (int i = 0; i < 2000; i++)
      tick($urandom_range(0, 9) < 3, $urandom_range(0, 639), $urandom_range(0, 479),
           $urandom_range(0, 1), $urandom_range(0, 639), $urandom_range(0, 479),
           $urandom_range(0, 3), $urandom_range(0, 149) == 0);
    idle(40);
    chk("rd_q_drained", 32'(rd_q.size()), 0);
    chk("fifo_drained", 32'(fifoCount), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
